// File: rtl/tl_fsm2.sv
// Traffic-light phase controller: a prescaler produces a slow tick, and a
// registered phase FSM advances START -> NS -> NY -> EW -> EY -> NS on ticks.
module tl_fsm2 #(
    parameter int COMPARE = 2499999,
    parameter int WIDTH   = 22,
    parameter int T_WIDTH = 12,
    parameter int NS_TIME = 90,
    parameter int EW_TIME = 60,
    parameter int Y_TIME  = 30
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    output logic [2:0] o_state,
    output logic       o_tick
);

    typedef enum logic [2:0] {
        START = 3'b111,
        NS    = 3'b011,
        NY    = 3'b010,
        EW    = 3'b000,
        EY    = 3'b001
    } state_t;

    localparam logic [WIDTH:0]     D_LAST  = (WIDTH+1)'(2*COMPARE+1);
    localparam logic [T_WIDTH-1:0] NS_LAST = T_WIDTH'(NS_TIME-1);
    localparam logic [T_WIDTH-1:0] EW_LAST = T_WIDTH'(EW_TIME-1);
    localparam logic [T_WIDTH-1:0] Y_LAST  = T_WIDTH'(Y_TIME-1);

    logic [WIDTH:0]     r_d;
    logic [2:0]         r_state;
    logic [T_WIDTH-1:0] r_t;
    logic               w_tick;
    logic               w_legal;
    logic [T_WIDTH-1:0] w_last;
    logic [2:0]         w_next;

    assign w_tick  = (r_d == D_LAST);
    assign o_tick  = w_tick;
    assign o_state = r_state;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_d <= '0;
        end else if (r_d == D_LAST) begin
            r_d <= '0;
        end else begin
            r_d <= r_d + 1'b1;
        end
    end

    // Last timer value and successor for each legal phase; START lasts one tick.
    always_comb begin
        w_legal = 1'b1;
        w_last  = '0;
        w_next  = START;
        case (r_state)
            START: begin
                w_next = NS;
            end
            NS: begin
                w_last = NS_LAST;
                w_next = NY;
            end
            NY: begin
                w_last = Y_LAST;
                w_next = EW;
            end
            EW: begin
                w_last = EW_LAST;
                w_next = EY;
            end
            EY: begin
                w_last = Y_LAST;
                w_next = NS;
            end
            default: begin
                w_legal = 1'b0;
            end
        endcase
    end

    // Illegal codes recover to START immediately, without waiting for a tick.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= START;
            r_t     <= '0;
        end else if (!w_legal) begin
            r_state <= START;
            r_t     <= '0;
        end else if (w_tick) begin
            if (r_t == w_last) begin
                r_state <= w_next;
                r_t     <= '0;
            end else begin
                r_t <= r_t + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tl_fsm2.sv
// Scoreboard bench for tl_fsm2 with a fast prescaler (COMPARE=1) and short phases.
module tb_tl_fsm2;

    typedef struct {
        logic [2:0] st;
        logic       tk;
        bit         chkT;
    } exp_t;

    logic       i_clk;
    logic       i_rst_n;
    logic [2:0] o_state;
    logic       o_tick;

    exp_t expQ[$];
    int   numCompared;
    int   numMismatched;
    int   phaseCnt;

    tl_fsm2 #(
        .COMPARE(1),
        .WIDTH  (2),
        .T_WIDTH(4),
        .NS_TIME(3),
        .EW_TIME(2),
        .Y_TIME (1)
    ) dut (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .o_state(o_state),
        .o_tick (o_tick)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string name, input int act, input int exp);
        numCompared++;
        if (act != exp) begin
            numMismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One expected sample per clock; the tick lands on every fourth prescaler count.
    task automatic pushPhase(input logic [2:0] st, input int n, input bit chkT);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.st   = st;
            e.tk   = (phaseCnt % 4 == 3);
            e.chkT = chkT;
            expQ.push_back(e);
            phaseCnt++;
        end
    endtask

    task automatic waitDrain(input string name);
        int budget;
        budget = 200;
        while (expQ.size() != 0 && budget > 0) begin
            @(posedge i_clk);
            budget--;
        end
        if (expQ.size() != 0) begin
            numCompared++;
            numMismatched++;
            $display("[TB] FAIL %s: %0d samples never compared, expected 0", name, expQ.size());
            expQ.delete();
        end
    endtask

    task automatic releaseReset();
        @(posedge i_clk);
        #1;
        i_rst_n  = 1'b1;
        phaseCnt = 0;
    endtask

    always @(negedge i_clk) begin
        if (expQ.size() != 0) begin
            exp_t e;
            e = expQ.pop_front();
            checkOutput("o_state", int'(o_state), int'(e.st));
            checkOutput("o_tick", int'(o_tick), int'(e.tk));
            if (e.chkT) checkOutput("timer", int'(dut.r_t), 0);
        end
    end

    task automatic applyStimulus();
        exp_t e;
        i_rst_n  = 1'b0;
        phaseCnt = 0;
        e.st = 3'b111; e.tk = 1'b0; e.chkT = 1'b1;
        expQ.push_back(e);
        waitDrain("reset");

        // Full sequence from release: 4 + 12 + 4 + 8 + 4 clocks, then NS again.
        releaseReset();
        pushPhase(3'b111, 4, 1'b0);
        pushPhase(3'b011, 12, 1'b0);
        pushPhase(3'b010, 4, 1'b0);
        pushPhase(3'b000, 8, 1'b0);
        pushPhase(3'b001, 4, 1'b0);
        pushPhase(3'b011, 12, 1'b0);
        waitDrain("sequence");

        #1;
        i_rst_n = 1'b0;
        #1;
        checkOutput("async_rst_ns", int'(o_state), 3'b111);

        releaseReset();
        pushPhase(3'b111, 4, 1'b0);
        pushPhase(3'b011, 12, 1'b0);
        pushPhase(3'b010, 4, 1'b0);
        pushPhase(3'b000, 3, 1'b0);
        waitDrain("to_ew");

        // Mid-EW reset: state jumps to START with no clock edge.
        #1;
        i_rst_n = 1'b0;
        #1;
        checkOutput("async_rst_ew", int'(o_state), 3'b111);
        checkOutput("async_rst_tick", int'(o_tick), 0);

        releaseReset();
        pushPhase(3'b111, 4, 1'b0);
        pushPhase(3'b011, 5, 1'b0);
        waitDrain("after_rst");

        // Now in NS with a nonzero timer; plant an illegal code before the next edge.
        #1;
        force dut.r_state = 3'b101;
        #1;
        release dut.r_state;
        pushPhase(3'b101, 1, 1'b0);
        pushPhase(3'b111, 2, 1'b1);
        pushPhase(3'b011, 12, 1'b0);
        pushPhase(3'b010, 1, 1'b0);
        waitDrain("recovery");
    endtask

    initial begin
        numCompared   = 0;
        numMismatched = 0;
        applyStimulus();
        #20;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule
